// File: rtl/nts_spi_api_bridge.sv
// SPI-slave to parallel register API bridge for the NTS engine.
// Optional burst mode with address auto-increment: define NTS_SPI_BURST_EN.
module nts_spi_api_bridge #(
  parameter int CPOL           = 0,
  parameter int CPHA           = 1,
  parameter int API_SLAVE_BITS = 2,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                                      i_clk,
  input  logic                                      i_areset_n,
  input  logic                                      i_spi_sclk,
  input  logic                                      i_spi_mosi,
  input  logic                                      i_spi_ss,
  output logic                                      o_spi_miso,
  output logic [2**API_SLAVE_BITS-1:0]              o_api_cs,
  output logic                                      o_api_we,
  output logic [ADDR_WIDTH-1:0]                     o_api_address,
  output logic [DATA_WIDTH-1:0]                     o_api_write_data,
  input  logic [DATA_WIDTH*2**API_SLAVE_BITS-1:0]   i_api_read_data,
  output logic                                      o_frame_error
);

  localparam int   NS       = 2**API_SLAVE_BITS;
  localparam int   HB       = API_SLAVE_BITS + 1 + ADDR_WIDTH;
  localparam int   MAXB     = (DATA_WIDTH > HB) ? DATA_WIDTH : HB;
  localparam int   CW       = $clog2(MAXB + 1);
  localparam logic IDLE_LVL = (CPOL != 0);

  typedef enum logic [2:0] {IDLE, HUNT, HEADER, WR_DATA, RD_ISSUE, RD_CAPTURE, RD_SHIFT} state_t;

  logic [SYNC_STAGES-1:0]    sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, ss_sync_q, ss_sync_d;
  logic                      sclk_last_q, sclk_last_d, ss_last_q, ss_last_d;
  logic                      sample_en_q, sample_en_d, shift_en_q, shift_en_d, mosi_bit_q, mosi_bit_d;
  logic                      ss_rise_q, ss_rise_d, ss_fall_q, ss_fall_d;
  state_t                    state_q, state_d;
  logic [CW-1:0]             bit_cnt_q, bit_cnt_d, shift_cnt_q, shift_cnt_d;
  logic                      done_q, done_d;
  logic [HB-1:0]             hdr_q, hdr_d, hdr_nxt;
  logic [API_SLAVE_BITS-1:0] slave_q, slave_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wsh_q, wsh_d, wd_nxt, msh_q, msh_d;
  logic [NS-1:0]             cs_q, cs_d;
  logic                      we_q, we_d, miso_q, miso_d, ferr_q, ferr_d;
  logic [ADDR_WIDTH-1:0]     aout_q, aout_d;
  logic [DATA_WIDTH-1:0]     wout_q, wout_d;

  logic sclk_s, rise, fall, lead, trail;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_last_q;
  assign fall   = ~sclk_s & sclk_last_q;
  assign lead   = (CPOL != 0) ? fall : rise;
  assign trail  = (CPOL != 0) ? rise : fall;

  function automatic logic [NS-1:0] onehot(input logic [API_SLAVE_BITS-1:0] s);
    return NS'(1) << s;
  endfunction

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], i_spi_ss};
    sclk_last_d = sclk_s;
    ss_last_d   = ss_sync_q[SYNC_STAGES-1];
    sample_en_d = (CPHA != 0) ? trail : lead;
    shift_en_d  = (CPHA != 0) ? lead : trail;
    mosi_bit_d  = mosi_sync_q[SYNC_STAGES-1];
    ss_rise_d   = ss_sync_q[SYNC_STAGES-1] & ~ss_last_q;
    ss_fall_d   = ~ss_sync_q[SYNC_STAGES-1] & ss_last_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_cnt_d = shift_cnt_q;
    done_d      = done_q;
    hdr_d       = hdr_q;
    slave_d     = slave_q;
    addr_d      = addr_q;
    wsh_d       = wsh_q;
    msh_d       = msh_q;
    cs_d        = '0;
    we_d        = we_q;
    aout_d      = aout_q;
    wout_d      = wout_q;
    miso_d      = miso_q;
    ferr_d      = 1'b0;
    hdr_nxt     = {hdr_q[HB-2:0], mosi_bit_q};
    wd_nxt      = {wsh_q[DATA_WIDTH-2:0], mosi_bit_q};

    // SS release has priority over any bit sampled in the same cycle
    if (ss_rise_q) begin
      if ((state_q == HEADER || state_q == WR_DATA || state_q == RD_SHIFT) &&
          !done_q && bit_cnt_q != '0)
        ferr_d = 1'b1;
      state_d     = IDLE;
      bit_cnt_d   = '0;
      shift_cnt_d = '0;
      done_d      = 1'b0;
      miso_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ss_fall_q) begin
          state_d   = HUNT;
          bit_cnt_d = '0;
          done_d    = 1'b0;
        end
        HUNT: if (sample_en_q && mosi_bit_q) begin
          state_d   = HEADER;
          bit_cnt_d = '0;
        end
        HEADER: if (sample_en_q) begin
          hdr_d = hdr_nxt;
          if (bit_cnt_q == CW'(HB - 1)) begin
            bit_cnt_d = '0;
            slave_d   = hdr_nxt[HB-1 -: API_SLAVE_BITS];
            addr_d    = hdr_nxt[ADDR_WIDTH-1:0];
            if (hdr_nxt[ADDR_WIDTH]) begin
              state_d = WR_DATA;
            end else begin
              cs_d    = onehot(hdr_nxt[HB-1 -: API_SLAVE_BITS]);
              we_d    = 1'b0;
              aout_d  = hdr_nxt[ADDR_WIDTH-1:0];
              state_d = RD_ISSUE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        WR_DATA: if (sample_en_q && !done_q) begin
          wsh_d = wd_nxt;
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            cs_d      = onehot(slave_q);
            we_d      = 1'b1;
            aout_d    = addr_q;
            wout_d    = wd_nxt;
`ifdef NTS_SPI_BURST_EN
            addr_d    = addr_q + 1'b1;
`else
            done_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        RD_ISSUE: state_d = RD_CAPTURE;
        RD_CAPTURE: begin
          msh_d       = i_api_read_data[DATA_WIDTH*slave_q +: DATA_WIDTH];
          shift_cnt_d = '0;
          state_d     = RD_SHIFT;
        end
        RD_SHIFT: begin
          if (shift_en_q) begin
            if (shift_cnt_q < CW'(DATA_WIDTH)) begin
              miso_d      = msh_q[DATA_WIDTH-1];
              msh_d       = {msh_q[DATA_WIDTH-2:0], 1'b0};
              shift_cnt_d = shift_cnt_q + 1'b1;
            end else begin
              miso_d = 1'b0;
            end
          end
          if (sample_en_q && !done_q) begin
            if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
              bit_cnt_d = '0;
`ifdef NTS_SPI_BURST_EN
              // next word is fetched now so it is loaded before its first shift edge
              addr_d    = addr_q + 1'b1;
              cs_d      = onehot(slave_q);
              we_d      = 1'b0;
              aout_d    = addr_q + 1'b1;
              state_d   = RD_ISSUE;
`else
              done_d    = 1'b1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      // SS chain starts "selected" so a frame already in progress cannot look like a fresh start
      sclk_sync_q <= {SYNC_STAGES{IDLE_LVL}};
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_last_q <= IDLE_LVL;
      ss_last_q   <= 1'b0;
      sample_en_q <= 1'b0;
      shift_en_q  <= 1'b0;
      mosi_bit_q  <= 1'b0;
      ss_rise_q   <= 1'b0;
      ss_fall_q   <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_cnt_q <= '0;
      done_q      <= 1'b0;
      hdr_q       <= '0;
      slave_q     <= '0;
      addr_q      <= '0;
      wsh_q       <= '0;
      msh_q       <= '0;
      cs_q        <= '0;
      we_q        <= 1'b0;
      aout_q      <= '0;
      wout_q      <= '0;
      miso_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_last_q <= sclk_last_d;
      ss_last_q   <= ss_last_d;
      sample_en_q <= sample_en_d;
      shift_en_q  <= shift_en_d;
      mosi_bit_q  <= mosi_bit_d;
      ss_rise_q   <= ss_rise_d;
      ss_fall_q   <= ss_fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      done_q      <= done_d;
      hdr_q       <= hdr_d;
      slave_q     <= slave_d;
      addr_q      <= addr_d;
      wsh_q       <= wsh_d;
      msh_q       <= msh_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      aout_q      <= aout_d;
      wout_q      <= wout_d;
      miso_q      <= miso_d;
      ferr_q      <= ferr_d;
    end
  end

  assign o_spi_miso       = miso_q;
  assign o_api_cs         = cs_q;
  assign o_api_we         = we_q;
  assign o_api_address    = aout_q;
  assign o_api_write_data = wout_q;
  assign o_frame_error    = ferr_q;

endmodule

// File: tb/tb_nts_spi_api_bridge.sv
// Scoreboard bench: a CPOL=0/CPHA=1 and a CPOL=1/CPHA=0 bridge driven by the same frames.
`timescale 1ns/1ps
module tb_nts_spi_api_bridge;
  localparam int SS_N = 2;
  localparam int H    = 8;
`ifdef NTS_SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  cs;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, sclk_a, sclk_b, mosi, ss;
  logic miso_a, miso_b, we_a, we_b, ferr_a, ferr_b;
  logic [3:0]   cs_a, cs_b;
  logic [7:0]   ad_a, ad_b;
  logic [31:0]  wd_a, wd_b;
  logic [127:0] rd_data;
  int cyc = 0, fe_a = 0, fe_b = 0, nchk = 0, nerr = 0;
  exp_t qa[$], qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nts_spi_api_bridge #(.CPOL(0), .CPHA(1), .API_SLAVE_BITS(2), .ADDR_WIDTH(8),
                       .DATA_WIDTH(32), .SYNC_STAGES(SS_N)) dut_a (
    .i_clk(clk), .i_areset_n(rst_n), .i_spi_sclk(sclk_a), .i_spi_mosi(mosi),
    .i_spi_ss(ss), .o_spi_miso(miso_a), .o_api_cs(cs_a), .o_api_we(we_a),
    .o_api_address(ad_a), .o_api_write_data(wd_a), .i_api_read_data(rd_data),
    .o_frame_error(ferr_a));

  nts_spi_api_bridge #(.CPOL(1), .CPHA(0), .API_SLAVE_BITS(2), .ADDR_WIDTH(8),
                       .DATA_WIDTH(32), .SYNC_STAGES(SS_N)) dut_b (
    .i_clk(clk), .i_areset_n(rst_n), .i_spi_sclk(sclk_b), .i_spi_mosi(mosi),
    .i_spi_ss(ss), .o_spi_miso(miso_b), .o_api_cs(cs_b), .o_api_we(we_b),
    .o_api_address(ad_b), .o_api_write_data(wd_b), .i_api_read_data(rd_data),
    .o_frame_error(ferr_b));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitors: every chip-select pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e, a;
    if (cs_a != 4'b0) begin
      if (qa.size() == 0) chk("cs_a_unexpected", {cs_a, ad_a}, 0);
      else begin
        e = qa.pop_front();
        a = {cs_a, we_a, ad_a, (e.we ? wd_a : 32'h0), 32'(cyc)};
        chk("cs_a", a, e);
      end
    end
    if (cs_b != 4'b0) begin
      if (qb.size() == 0) chk("cs_b_unexpected", {cs_b, ad_b}, 0);
      else begin
        e = qb.pop_front();
        a = {cs_b, we_b, ad_b, (e.we ? wd_b : 32'h0), 32'(cyc)};
        chk("cs_b", a, e);
      end
    end
    if (ferr_a) fe_a <= fe_a + 1;
    if (ferr_b) fe_b <= fe_b + 1;
  end

  // One bit period: setup, leading edge, trailing edge, gap.
  // Device A samples on the trailing edge, device B on the leading edge.
  task automatic xfer_bit(input logic b, input logic evt, input exp_t e,
                          output logic ma, output logic mb);
    exp_t x;
    x = e;
    mosi = b;
    repeat (H) @(negedge clk);
    mb = miso_b;
    if (evt) begin x.cyc = 32'(cyc + SS_N + 2); qb.push_back(x); end
    sclk_a = 1'b1; sclk_b = 1'b0;
    repeat (H) @(negedge clk);
    ma = miso_a;
    if (evt) begin x.cyc = 32'(cyc + SS_N + 2); qa.push_back(x); end
    sclk_a = 1'b0; sclk_b = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // z leading zeros, header, n full words, t trailing partial bits
  task automatic run_frame(input int z, input logic [1:0] s, input logic we, input logic [7:0] a,
                           input int n, input int t, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [127:0] rdv);
    logic [31:0] wd, ga, gb, want;
    logic [11:0] hdr;
    logic ma, mb, evt, exp_err;
    exp_t e;
    int fa0, fb0;
    rd_data = rdv;
    fa0 = fe_a; fb0 = fe_b;
    ss = 1'b0;
    repeat (2*H) @(negedge clk);
    e = '0;
    for (int i = 0; i < z; i++) xfer_bit(1'b0, 1'b0, e, ma, mb);
    hdr = {1'b1, s, we, a};
    e.cs = 4'b0001 << s; e.we = 1'b0; e.addr = a; e.wd = 32'h0;
    for (int i = 11; i >= 0; i--) xfer_bit(hdr[i], (i == 0) && !we, e, ma, mb);
    for (int k = 0; k < n; k++) begin
      wd = we ? ((k == 0) ? w0 : w1) : 32'h0;
      e.cs = 4'b0001 << s;
      e.we = we;
      e.addr = we ? a + 8'(k) : a + 8'(k + 1);
      e.wd = wd;
      for (int j = 31; j >= 0; j--) begin
        evt = (j == 0) && (we ? (BURST || k == 0) : BURST);
        xfer_bit(wd[j], evt, e, ma, mb);
        ga[j] = ma; gb[j] = mb;
      end
      if (!we) begin
        want = (BURST || k == 0) ? rdv[32*s +: 32] : 32'h0;
        chk("miso_a", ga, want);
        chk("miso_b", gb, want);
      end
    end
    for (int i = 0; i < t; i++) xfer_bit(1'($urandom_range(0, 1)), 1'b0, e, ma, mb);
    repeat (H) @(negedge clk);
    ss = 1'b1;
    repeat (4*H) @(negedge clk);
    exp_err = (t > 0) && (BURST || n == 0);
    chk("ferr_a", fe_a - fa0, exp_err);
    chk("ferr_b", fe_b - fb0, exp_err);
    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);
    chk("miso_idle", {miso_a, miso_b}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ma, mb;
    exp_t e;
    int fa0;
    rst_n = 1'b0; sclk_a = 1'b0; sclk_b = 1'b1; mosi = 1'b0; ss = 1'b1; rd_data = '0;
    e = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_a", {miso_a, cs_a, we_a, ad_a, wd_a, ferr_a}, 0);
    chk("reset_b", {miso_b, cs_b, we_b, ad_b, wd_b, ferr_b}, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    run_frame(0, 2'd1, 1'b1, 8'hff, 1, 0, 32'h12341234, 32'h0, '0);
    run_frame(0, 2'd2, 1'b0, 8'h33, 1, 0, 32'h0, 32'h0,
              128'hdeadbeef_baadf00d_1cee7eaa_12345678);
    run_frame(0, 2'd3, 1'b1, 8'hff, 2, 0, 32'h11111111, 32'h22222222, '0);
    run_frame(0, 2'd1, 1'b1, 8'h10, 0, 20, 32'h0, 32'h0, '0);
    run_frame(0, 2'd0, 1'b1, 8'h00, 1, 0, 32'hcafef00d, 32'h0, '0);
    run_frame(5, 2'd2, 1'b1, 8'h5a, 1, 0, 32'ha5a50ff0, 32'h0, '0);

    // Asynchronous reset in the middle of a header
    fa0 = fe_a;
    ss = 1'b0;
    repeat (2*H) @(negedge clk);
    xfer_bit(1'b1, 1'b0, e, ma, mb);
    xfer_bit(1'b0, 1'b1 ^ 1'b1, e, ma, mb);
    xfer_bit(1'b1, 1'b0, e, ma, mb);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_a", {miso_a, cs_a, we_a, ad_a, wd_a, ferr_a}, 0);
    chk("midreset_b", {miso_b, cs_b, we_b, ad_b, wd_b, ferr_b}, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (4*H) @(negedge clk);
    chk("midreset_ferr", fe_a - fa0, 0);
    run_frame(0, 2'd3, 1'b1, 8'h81, 1, 0, 32'h0badc0de, 32'h0, '0);

    for (int r = 0; r < 10; r++) begin
      run_frame($urandom_range(0, 3), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 0,
                $urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
